systolic_drain: RTL and testbench
=================================

Name: systolic_drain

Overview:
- Output-side collector at the bottom edge of the weight-stationary PE array.
- PEs emit partial sums on out_down skewed by one cycle per column: column j of row r leaves the array one cycle after column j-1.
- This block de-skews the ARRAY_SIZE column streams, assembles each result row, and writes it to the output global buffer as one word at consecutive addresses.
- Under FSM control it signals done when the programmed row count has been written.

Parameters:
- ARRAY_SIZE, 4: PE columns (and rows) in the array.
- DATA_SIZE, 16: width of each out_down partial sum; matches the PE data width.
- ADDR_W, 8: output buffer address width.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; latches base_addr and num_rows and arms the block.
- base_addr  input  ADDR_W  buffer address of result row 0.
- num_rows  input  ADDR_W  number of result rows to collect (0 allowed).
- col0_valid  input  1  column 0 of psum_in carries a valid row this cycle.
- psum_in  input  ARRAY_SIZE*DATA_SIZE  bottom-edge out_down bus; column j at bits [(j+1)*DATA_SIZE-1 : j*DATA_SIZE].
- wr_en  output  1  buffer write strobe.
- wr_addr  output  ADDR_W  buffer write address.
- wr_data  output  ARRAY_SIZE*DATA_SIZE  de-skewed row; column j occupies the same bit slice as in psum_in.
- busy  output  1  high in ARMED and DRAIN.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset values: wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0. All delay lines and counters are cleared and the FSM returns to IDLE. Reset mid-operation abandons the job: no further writes and no done.
- De-skew path:
  - Column j passes through ARRAY_SIZE-1-j registers, so column ARRAY_SIZE-1 has no delay.
  - A valid bit travels down an ARRAY_SIZE-1 stage chain alongside column 0.
  - The chain's output marks an aligned row.
- Timing:
  - If col0_valid is high at cycle T, columns 1..ARRAY_SIZE-1 of that row must be on psum_in at T+1..T+ARRAY_SIZE-1.
  - The row is written with wr_en=1 at cycle T+ARRAY_SIZE (ARRAY_SIZE-1 de-skew stages plus one registered output stage).
- Throughput: one row per cycle; back-to-back col0_valid is supported. There is no backpressure, and every write is accepted by the buffer.
- FSM states:
  - IDLE: col0_valid ignored. On start, latch the parameters and clear both counters. Go to DONE if num_rows=0, else go to ARMED.
  - ARMED: accept col0_valid pulses into the chain and increment acc_cnt. When acc_cnt reaches num_rows, go to DRAIN. Further col0_valid pulses are not injected.
  - DRAIN: wait until wr_cnt equals num_rows, then go to DONE.
  - DONE: done=1 for exactly one cycle, then go to IDLE.
- Write side:
  - Each aligned row drives wr_addr = base_addr + wr_cnt and increments wr_cnt.
  - Address arithmetic is modulo 2^ADDR_W (wrap-around allowed).
- start outside IDLE is ignored.
- Simultaneous start and col0_valid in IDLE: the col0_valid is ignored.
- With num_rows=0: done rises on the cycle after start and no write occurs.
- wr_data holds its last value when wr_en=0.

Optional Feature:
- Macro: DRAIN_RELU_EN.
- Defined: each column value is treated as signed two's complement. Negative values are replaced by 0 in the output register, with no added latency.
- Undefined: values pass through unmodified.

Decomposition:
- Shared package/define file holds:
  - ARRAY_SIZE, DATA_SIZE and ADDR_W defaults.
  - FSM state encodings: IDLE=0, ARMED=1, DRAIN=2, DONE=3.
- Sub-module deskew_line: a parameterized DEPTH x DATA_SIZE register chain. DEPTH=0 is a passthrough. It is instantiated per column and once, 1 bit wide, for the valid chain.

Test Plan (ARRAY_SIZE=4, DATA_SIZE=16):
- Single row:
  - Stimulus: start with base_addr=8'h10, num_rows=1. col0_valid at cycle T; psum_in presents columns 0..3 = 1,2,3,4 at cycles T..T+3.
  - Response: one write at T+4, wr_addr=8'h10, wr_data columns = 1,2,3,4. done on the following cycle.
- Back-to-back rows:
  - Stimulus: num_rows=3 with col0_valid on 3 consecutive cycles; row r columns = 10r+j.
  - Response: writes on 3 consecutive cycles to base, base+1, base+2 with correctly aligned values.
- Wrap and excess rows:
  - Stimulus: base_addr=8'hFE, num_rows=3, followed by a 4th col0_valid.
  - Response: addresses FE, FF, 00 are written. The 4th row is never written.
- Zero rows and start while busy:
  - Stimulus: num_rows=0.
  - Response: done one cycle after start, no wr_en.
  - Stimulus: start pulse issued during DRAIN.
  - Response: ignored; base_addr and row count are unchanged.
- Reset mid-drain:
  - Stimulus: rst asserted one cycle after row 0 is accepted.
  - Response: all outputs are 0 the next cycle; no write and no done afterwards.
- DRAIN_RELU_EN:
  - Stimulus: columns = -5, 7, 16'h8000, 0.
  - Response with macro defined: written row = 0, 7, 0, 0.
  - Response without macro: written row = FFFB, 0007, 8000, 0000.

Source files
------------

// File: rtl/systolic_drain_pkg.sv
// Shared definitions for the systolic_drain output collector: default
// geometry and the FSM state encoding.
`timescale 1ns/1ps
package systolic_drain_pkg;

  localparam int DEF_ARRAY_SIZE = 4;
  localparam int DEF_DATA_SIZE  = 16;
  localparam int DEF_ADDR_W     = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/systolic_drain_deskew_line.sv
// deskew_line: DEPTH-stage register chain of WIDTH bits.
// DEPTH=0 degenerates to a plain wire.
`timescale 1ns/1ps
module deskew_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_pass
      // No storage needed; clock and reset are intentionally unused here.
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst;
      assign dout = din;
    end else begin : g_chain
      logic [WIDTH-1:0] stage_reg [DEPTH];

      // Shift the sample one stage per clock; reset flushes the whole line.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < DEPTH; i++) stage_reg[i] <= '0;
        end else begin
          stage_reg[0] <= din;
          for (int i = 1; i < DEPTH; i++) stage_reg[i] <= stage_reg[i-1];
        end
      end

      assign dout = stage_reg[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/systolic_drain.sv
// systolic_drain: de-skews the bottom-edge column streams of the PE array,
// assembles each result row and writes it to the output buffer at
// consecutive addresses, pulsing done once the programmed row count is out.
// Optional build macro DRAIN_RELU_EN clamps negative column values to zero
// in the output register.
`timescale 1ns/1ps
module systolic_drain
  import systolic_drain_pkg::*;
#(
  parameter int ARRAY_SIZE = DEF_ARRAY_SIZE,
  parameter int DATA_SIZE  = DEF_DATA_SIZE,
  parameter int ADDR_W     = DEF_ADDR_W
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [ADDR_W-1:0]              base_addr,
  input  logic [ADDR_W-1:0]              num_rows,
  input  logic                           col0_valid,
  input  logic [ARRAY_SIZE*DATA_SIZE-1:0] psum_in,
  output logic                           wr_en,
  output logic [ADDR_W-1:0]              wr_addr,
  output logic [ARRAY_SIZE*DATA_SIZE-1:0] wr_data,
  output logic                           busy,
  output logic                           done
);

  localparam int ROW_W = ARRAY_SIZE * DATA_SIZE;

  state_t                state_reg, state_next;
  logic [ADDR_W-1:0]     base_reg;
  logic [ADDR_W-1:0]     num_reg;
  logic [ADDR_W-1:0]     acc_cnt_reg;
  logic [ADDR_W-1:0]     acc_cnt_inc;
  logic [ADDR_W-1:0]     wr_cnt_reg;
  logic                  inject;
  logic                  row_valid;
  logic [ROW_W-1:0]      aligned_row;
  logic [ROW_W-1:0]      out_row;
  logic                  wr_en_reg;
  logic [ADDR_W-1:0]     wr_addr_reg;
  logic [ROW_W-1:0]      wr_data_reg;

  assign acc_cnt_inc = acc_cnt_reg + ADDR_W'(1);

  // Valid marker rides alongside column 0, so its output flags an aligned row.
  deskew_line #(
    .DEPTH(ARRAY_SIZE-1),
    .WIDTH(1)
  ) u_valid_line (
    .clk (clk),
    .rst (rst),
    .din (inject),
    .dout(row_valid)
  );

  // Column j arrives j cycles after column 0, so it is delayed by
  // ARRAY_SIZE-1-j stages to line up with the last column.
  genvar gi;
  generate
    for (gi = 0; gi < ARRAY_SIZE; gi++) begin : g_col
      deskew_line #(
        .DEPTH(ARRAY_SIZE-1-gi),
        .WIDTH(DATA_SIZE)
      ) u_col_line (
        .clk (clk),
        .rst (rst),
        .din (psum_in[gi*DATA_SIZE +: DATA_SIZE]),
        .dout(aligned_row[gi*DATA_SIZE +: DATA_SIZE])
      );

`ifdef DRAIN_RELU_EN
      // Signed clamp: a set sign bit means negative, which becomes zero.
      assign out_row[gi*DATA_SIZE +: DATA_SIZE] =
        aligned_row[(gi+1)*DATA_SIZE-1] ? '0 : aligned_row[gi*DATA_SIZE +: DATA_SIZE];
`else
      assign out_row[gi*DATA_SIZE +: DATA_SIZE] = aligned_row[gi*DATA_SIZE +: DATA_SIZE];
`endif
    end
  endgenerate

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state, row injection and status outputs.
  always_comb begin
    state_next = state_reg;
    inject     = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) state_next = (num_rows == '0) ? DONE : ARMED;
      end
      ARMED: begin
        busy = 1'b1;
        if (col0_valid) begin
          inject = 1'b1;
          if (acc_cnt_inc == num_reg) state_next = DRAIN;
        end
      end
      DRAIN: begin
        busy = 1'b1;
        if (wr_cnt_reg == num_reg) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Job parameters and row counters; start is only honoured from IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      base_reg    <= '0;
      num_reg     <= '0;
      acc_cnt_reg <= '0;
      wr_cnt_reg  <= '0;
    end else begin
      if (state_reg == IDLE && start) begin
        base_reg    <= base_addr;
        num_reg     <= num_rows;
        acc_cnt_reg <= '0;
        wr_cnt_reg  <= '0;
      end else begin
        if (inject)    acc_cnt_reg <= acc_cnt_inc;
        if (row_valid) wr_cnt_reg  <= wr_cnt_reg + ADDR_W'(1);
      end
    end
  end

  // Registered write port; address and data hold between writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en_reg   <= 1'b0;
      wr_addr_reg <= '0;
      wr_data_reg <= '0;
    end else begin
      wr_en_reg <= row_valid;
      if (row_valid) begin
        wr_addr_reg <= base_reg + wr_cnt_reg;
        wr_data_reg <= out_row;
      end
    end
  end

  assign wr_en   = wr_en_reg;
  assign wr_addr = wr_addr_reg;
  assign wr_data = wr_data_reg;

endmodule

// File: tb/tb_systolic_drain.sv
// Scoreboard bench for systolic_drain (ARRAY_SIZE=4, DATA_SIZE=16, ADDR_W=8).
`timescale 1ns/1ps
module tb_systolic_drain;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  base_addr;
  logic [7:0]  num_rows;
  logic        col0_valid;
  logic [63:0] psum_in;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [63:0] wr_data;
  logic        busy;
  logic        done;

  systolic_drain #(
    .ARRAY_SIZE(4),
    .DATA_SIZE (16),
    .ADDR_W    (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .num_rows  (num_rows),
    .col0_valid(col0_valid),
    .psum_in   (psum_in),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [7:0]  addr;
    logic [63:0] data;
  } wr_t;

  wr_t  exp_q[$];
  int   done_q[$];
  int   zero_q[$];

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic end_req = 1'b0;
  logic end_done = 1'b0;

  logic [15:0] rows_mem [0:7][0:3];
  logic [15:0] exp_mem  [0:7][0:3];

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: every DUT event is matched against the scoreboard queues.
  initial forever begin
    @(negedge clk);
    if (wr_en) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr=%h data=%h at cycle %0d, required no write",
                 wr_addr, wr_data, cyc);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        checks++;
        if (wr_addr !== e.addr || wr_data !== e.data || cyc != e.cyc) begin
          errors++;
          $display("FAIL write: got addr=%h data=%h cycle=%0d, required addr=%h data=%h cycle=%0d",
                   wr_addr, wr_data, cyc, e.addr, e.data, e.cyc);
        end else begin
          $display("write ok: addr=%h data=%h cycle=%0d", wr_addr, wr_data, cyc);
        end
      end
    end
    if (done) begin
      checks++;
      if (done_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: got done at cycle %0d, required none", cyc);
      end else begin
        int d;
        d = done_q.pop_front();
        if (d != cyc) begin
          errors++;
          $display("FAIL done_cycle: got cycle %0d, required cycle %0d", cyc, d);
        end else begin
          $display("done ok: cycle=%0d", cyc);
        end
      end
    end
    if (zero_q.size() > 0 && zero_q[0] == cyc) begin
      void'(zero_q.pop_front());
      checks++;
      if (wr_en !== 1'b0 || wr_addr !== 8'h00 || wr_data !== 64'h0 || busy !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL reset_state: got wr_en=%b wr_addr=%h wr_data=%h busy=%b done=%b, required all 0",
                 wr_en, wr_addr, wr_data, busy, done);
      end else begin
        $display("reset state ok: cycle=%0d", cyc);
      end
    end
    if (end_req && !end_done) begin
      checks++;
      if (exp_q.size() != 0) begin
        errors++;
        $display("FAIL missing_writes: got %0d outstanding, required 0", exp_q.size());
      end
      checks++;
      if (done_q.size() != 0 || zero_q.size() != 0) begin
        errors++;
        $display("FAIL missing_done: got %0d done / %0d reset checks outstanding, required 0",
                 done_q.size(), zero_q.size());
      end
      end_done = 1'b1;
    end
  end

  // One cycle of start, optionally with a simultaneous (ignored) col0_valid.
  task automatic do_start(input logic [7:0] base, input logic [7:0] num, input logic with_valid,
                          output int s);
    @(posedge clk); #1;
    s          = cyc;
    start      = 1'b1;
    base_addr  = base;
    num_rows   = num;
    col0_valid = with_valid;
    psum_in    = {$urandom, $urandom};
  endtask

  // Drive n_valid skewed rows from rows_mem; the first n_inj are expected
  // to be written. A start with other parameters may be issued at step start_k.
  task automatic drive_rows(input int n_valid, input int n_inj, input logic [7:0] base,
                            input int start_k, input logic [7:0] late_base,
                            input logic [7:0] late_num);
    int c0;
    for (int k = 0; k < n_valid + 3; k++) begin
      @(posedge clk); #1;
      if (k == 0) begin
        c0 = cyc;
        for (int r = 0; r < n_inj; r++) begin
          wr_t e;
          e.cyc  = c0 + r + 4;
          e.addr = base + 8'(r);
          for (int j = 0; j < 4; j++) e.data[j*16 +: 16] = exp_mem[r][j];
          exp_q.push_back(e);
        end
        if (n_inj > 0) done_q.push_back(c0 + n_inj + 4);
      end
      start = (k == start_k);
      if (k == start_k) begin
        base_addr = late_base;
        num_rows  = late_num;
      end
      col0_valid = (k < n_valid);
      for (int j = 0; j < 4; j++) begin
        int r;
        r = k - j;
        if (r >= 0 && r < n_valid) psum_in[j*16 +: 16] = rows_mem[r][j];
        else                       psum_in[j*16 +: 16] = 16'($urandom);
      end
    end
  endtask

  // Idle the inputs and wait (bounded) for the scoreboard to drain.
  task automatic wait_quiet();
    int n;
    @(posedge clk); #1;
    start      = 1'b0;
    col0_valid = 1'b0;
    n = 0;
    while ((exp_q.size() != 0 || done_q.size() != 0) && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    int s;
    rst        = 1'b1;
    start      = 1'b0;
    base_addr  = 8'h00;
    num_rows   = 8'h00;
    col0_valid = 1'b0;
    psum_in    = 64'h0;
    repeat (3) @(posedge clk);
    #1;
    zero_q.push_back(cyc);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single row, with an ignored col0_valid alongside start.
    rows_mem[0] = '{16'd1, 16'd2, 16'd3, 16'd4};
    exp_mem[0]  = '{16'd1, 16'd2, 16'd3, 16'd4};
    do_start(8'h10, 8'd1, 1'b1, s);
    drive_rows(1, 1, 8'h10, -1, 8'h00, 8'h00);
    wait_quiet();

    // Back-to-back rows, row r column j = 10r+j.
    for (int r = 0; r < 3; r++)
      for (int j = 0; j < 4; j++) begin
        rows_mem[r][j] = 16'(10*r + j);
        exp_mem[r][j]  = 16'(10*r + j);
      end
    do_start(8'h20, 8'd3, 1'b0, s);
    drive_rows(3, 3, 8'h20, -1, 8'h00, 8'h00);
    wait_quiet();

    // Address wrap with a 4th, excess row that must not be written.
    rows_mem[0] = '{16'h0101, 16'h0102, 16'h0103, 16'h0104};
    rows_mem[1] = '{16'h0201, 16'h0202, 16'h0203, 16'h0204};
    rows_mem[2] = '{16'h0301, 16'h0302, 16'h0303, 16'h0304};
    rows_mem[3] = '{16'h0401, 16'h0402, 16'h0403, 16'h0404};
    exp_mem[0]  = '{16'h0101, 16'h0102, 16'h0103, 16'h0104};
    exp_mem[1]  = '{16'h0201, 16'h0202, 16'h0203, 16'h0204};
    exp_mem[2]  = '{16'h0301, 16'h0302, 16'h0303, 16'h0304};
    do_start(8'hFE, 8'd3, 1'b0, s);
    drive_rows(4, 3, 8'hFE, -1, 8'h00, 8'h00);
    wait_quiet();

    // Zero rows: done on the cycle after start, no write.
    do_start(8'h30, 8'd0, 1'b0, s);
    done_q.push_back(s + 1);
    wait_quiet();

    // start during DRAIN is ignored: base/count stay 0x40 / 2.
    rows_mem[0] = '{16'h00A1, 16'h00A2, 16'h00A3, 16'h00A4};
    rows_mem[1] = '{16'h00B1, 16'h00B2, 16'h00B3, 16'h00B4};
    exp_mem[0]  = '{16'h00A1, 16'h00A2, 16'h00A3, 16'h00A4};
    exp_mem[1]  = '{16'h00B1, 16'h00B2, 16'h00B3, 16'h00B4};
    do_start(8'h40, 8'd2, 1'b0, s);
    drive_rows(2, 2, 8'h40, 3, 8'h80, 8'd5);
    wait_quiet();

    // Reset one cycle after row 0 is accepted: no write, no done.
    do_start(8'h50, 8'd2, 1'b0, s);
    @(posedge clk); #1;
    start      = 1'b0;
    col0_valid = 1'b1;
    psum_in    = 64'h0004_0003_0002_0001;
    @(posedge clk); #1;
    col0_valid = 1'b0;
    rst        = 1'b1;
    zero_q.push_back(cyc + 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;

    // Signed clamp row: -5, 7, 0x8000, 0.
    rows_mem[0] = '{16'hFFFB, 16'h0007, 16'h8000, 16'h0000};
`ifdef DRAIN_RELU_EN
    exp_mem[0]  = '{16'h0000, 16'h0007, 16'h0000, 16'h0000};
`else
    exp_mem[0]  = '{16'hFFFB, 16'h0007, 16'h8000, 16'h0000};
`endif
    do_start(8'h60, 8'd1, 1'b0, s);
    drive_rows(1, 1, 8'h60, -1, 8'h00, 8'h00);
    wait_quiet();

    end_req = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
